// File: rtl/coin_acceptor_frontend.sv
// rtl/coin_acceptor_frontend.sv - synchronize, debounce and queue three coin-sensor lines
module coin_acceptor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sense_25,
  input  logic                          sense_50,
  input  logic                          sense_100,
  input  logic                          out_ready,
  output logic [1:0]                    coin,
  output logic                          coin_valid,
  output logic                          jam,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [7:0]        DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEPTH   = CNT_W'(FIFO_DEPTH);

  // Line index 0 = 25c, 1 = 50c, 2 = 1 birr; coin code is index + 1.
  logic [2:0] raw;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] f;
  logic [2:0] f_d;
  logic [2:0] rise;
  logic [7:0] db_cnt [3];

  logic             push;
  logic             multi;
  logic [1:0]       push_code;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       mem [FIFO_DEPTH];

  assign raw  = {sense_100, sense_50, sense_25};
  assign rise = f & ~f_d;

  // Two-flop synchronizer per raw sensor line.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: the filtered level follows s2 only after it has disagreed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      f   <= '0;
      f_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      f_d <= f;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == f[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          f[i]      <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Arbitrate same-cycle filtered rises: a lone rise pushes its code, several rises are a jam.
  always_comb begin
    push      = 1'b0;
    multi     = 1'b0;
    push_code = 2'b00;
    case (rise)
      3'b000: ;
      3'b001: begin push = 1'b1; push_code = 2'b01; end
      3'b010: begin push = 1'b1; push_code = 2'b10; end
      3'b100: begin push = 1'b1; push_code = 2'b11; end
      default: multi = 1'b1;
    endcase
  end

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full queue survives it.
  assign pop     = !empty && (!coin_valid || out_ready);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Queue storage; contents need no reset since the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_code;
  end

  // Queue pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // Output register, jam pulse and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      coin       <= 2'b00;
      coin_valid <= 1'b0;
      jam        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      jam <= multi;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        coin       <= mem[rd_ptr];
        coin_valid <= 1'b1;
      end else if (coin_valid && out_ready) begin
        coin       <= 2'b00;
        coin_valid <= 1'b0;
      end
    end
  end

  assign fifo_count = count;

endmodule
